// File: rtl/refill_pkg.sv
// Shared definitions for the cache line refill controller: FSM encoding and
// parameter defaults used by refill_ctrl.
package refill_pkg;

    localparam int IDX_W_DEFAULT      = 6;
    localparam int TAG_W_DEFAULT      = 20;
    localparam int WORD_W_DEFAULT     = 32;
    localparam int LINE_WORDS_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        FILL   = 2'd2,
        COMMIT = 2'd3
    } refill_state_t;

endpackage : refill_pkg

// File: rtl/refill_ctrl.sv
// Cache line refill controller: accepts a miss, issues one line read, writes the
// returned beats straight into the data array and commits the tag at the end.
module refill_ctrl
    import refill_pkg::*;
#(
    parameter int IDX_W      = IDX_W_DEFAULT,
    parameter int TAG_W      = TAG_W_DEFAULT,
    parameter int WORD_W     = WORD_W_DEFAULT,
    parameter int LINE_WORDS = LINE_WORDS_DEFAULT,
    localparam int OFF_W     = $clog2(LINE_WORDS)
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     miss_valid,
    output logic                     miss_ready,
    input  logic [IDX_W-1:0]         miss_index,
    input  logic [TAG_W-1:0]         miss_tag,

    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic [TAG_W+IDX_W-1:0]   mem_req_addr,

    input  logic                     mem_rsp_valid,
    input  logic [WORD_W-1:0]        mem_rsp_data,
    input  logic                     mem_rsp_last,

    output logic                     data_wen,
    output logic [IDX_W+OFF_W-1:0]   data_waddr,
    output logic [WORD_W-1:0]        data_wdata,

    output logic                     tag_wen,
    output logic [IDX_W-1:0]         tag_waddr,
    output logic [TAG_W:0]           tag_wdata,

    output logic                     done,
    output logic                     err
);

    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    refill_state_t      state_q, state_d;
    logic [OFF_W-1:0]   beat_q,  beat_d;
    logic               err_q,   err_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [TAG_W-1:0]   tag_q,   tag_d;
    // Keeps miss_ready low while in reset and lets it rise on the first edge after release.
    logic               ready_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            tag_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            tag_q   <= tag_d;
            ready_q <= 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        err_d         = err_q;
        idx_d         = idx_q;
        tag_d         = tag_q;

        miss_ready    = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        data_wen      = 1'b0;
        data_waddr    = '0;
        data_wdata    = '0;
        tag_wen       = 1'b0;
        tag_waddr     = '0;
        tag_wdata     = '0;
        done          = 1'b0;
        err           = 1'b0;

        case (state_q)
            IDLE: begin
                miss_ready = ready_q;
                if (ready_q && miss_valid) begin
                    idx_d   = miss_index;
                    tag_d   = miss_tag;
                    err_d   = 1'b0;
                    state_d = REQ;
                end
            end

            REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {tag_q, idx_q};
                if (mem_req_ready) begin
                    beat_d  = '0;
                    state_d = FILL;
                end
            end

            FILL: begin
                data_wen   = mem_rsp_valid;
                data_waddr = {idx_q, beat_q};
                data_wdata = mem_rsp_data;
                if (mem_rsp_valid) begin
                    beat_d = beat_q + 1'b1;
                    // The final slot always ends the line, so a missing last can never wrap into a fifth write.
                    if (beat_q == LAST_BEAT) begin
                        err_d   = ~mem_rsp_last;
                        state_d = COMMIT;
                    end else if (mem_rsp_last) begin
                        err_d   = 1'b1;
                        state_d = COMMIT;
                    end
                end
            end

            COMMIT: begin
                tag_wen   = 1'b1;
                tag_waddr = idx_q;
                tag_wdata = {~err_q, tag_q};
                done      = 1'b1;
                err       = err_q;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule : refill_ctrl

// File: tb/tb_refill_ctrl.sv
// Scenario-driven bench for refill_ctrl; a negedge monitor checks every data and
// tag write against expectations queued when the stimulus is driven.
module tb_refill_ctrl;

    localparam int IDX_W      = 6;
    localparam int TAG_W      = 20;
    localparam int WORD_W     = 32;
    localparam int LINE_WORDS = 4;
    localparam int OFF_W      = 2;

    logic                   clk;
    logic                   reset;
    logic                   miss_valid;
    logic                   miss_ready;
    logic [IDX_W-1:0]       miss_index;
    logic [TAG_W-1:0]       miss_tag;
    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic [TAG_W+IDX_W-1:0] mem_req_addr;
    logic                   mem_rsp_valid;
    logic [WORD_W-1:0]      mem_rsp_data;
    logic                   mem_rsp_last;
    logic                   data_wen;
    logic [IDX_W+OFF_W-1:0] data_waddr;
    logic [WORD_W-1:0]      data_wdata;
    logic                   tag_wen;
    logic [IDX_W-1:0]       tag_waddr;
    logic [TAG_W:0]         tag_wdata;
    logic                   done;
    logic                   err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [IDX_W+OFF_W+WORD_W-1:0] wr_q[$];
    logic [IDX_W+TAG_W+1:0]        tag_q[$];

    refill_ctrl #(
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W),
        .WORD_W     (WORD_W),
        .LINE_WORDS (LINE_WORDS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .miss_valid    (miss_valid),
        .miss_ready    (miss_ready),
        .miss_index    (miss_index),
        .miss_tag      (miss_tag),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_last  (mem_rsp_last),
        .data_wen      (data_wen),
        .data_waddr    (data_waddr),
        .data_wdata    (data_wdata),
        .tag_wen       (tag_wen),
        .tag_waddr     (tag_waddr),
        .tag_wdata     (tag_wdata),
        .done          (done),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every write the DUT makes must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [IDX_W+OFF_W+WORD_W-1:0] exp_wr;
        logic [IDX_W+TAG_W+1:0]        exp_tag;
        if (data_wen === 1'b1) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_data_write addr=%h data=%h", data_waddr, data_wdata);
            end else begin
                exp_wr = wr_q.pop_front();
                if ({data_waddr, data_wdata} !== exp_wr) begin
                    errors++;
                    $display("[TB] FAIL data_write got addr=%h data=%h expected addr=%h data=%h",
                             data_waddr, data_wdata, exp_wr[IDX_W+OFF_W+WORD_W-1:WORD_W], exp_wr[WORD_W-1:0]);
                end
            end
        end
        if (tag_wen === 1'b1) begin
            checks++;
            if (tag_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_tag_write addr=%h data=%h", tag_waddr, tag_wdata);
            end else begin
                exp_tag = tag_q.pop_front();
                if ({tag_waddr, tag_wdata, err, done} !== {exp_tag, 1'b1}) begin
                    errors++;
                    $display("[TB] FAIL tag_write got addr=%h data=%h err=%b done=%b expected addr=%h data=%h err=%b done=1",
                             tag_waddr, tag_wdata, err, done,
                             exp_tag[IDX_W+TAG_W+1:TAG_W+2], exp_tag[TAG_W+1:1], exp_tag[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic valid, input logic [WORD_W-1:0] data, input logic last);
        mem_rsp_valid = valid;
        mem_rsp_data  = data;
        mem_rsp_last  = last;
        tick();
    endtask

    task automatic issue_miss(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag, output int acc_cyc);
        int n = 0;
        while (miss_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (miss_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL miss_ready_timeout got=%b expected=1", miss_ready);
        end
        miss_valid = 1'b1;
        miss_index = idx;
        miss_tag   = tag;
        acc_cyc    = cyc;
        tick();
        miss_valid = 1'b0;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (wr_q.size() != 0 || tag_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_drained pending writes=%0d tags=%0d expected 0 and 0", name, wr_q.size(), tag_q.size());
        end
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        miss_valid    = 1'b0;
        miss_index    = '0;
        miss_tag      = '0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        mem_rsp_last  = 1'b0;
        @(negedge clk);
        checks++;
        if ({miss_ready, mem_req_valid, mem_req_addr, data_wen, tag_wen, done, err} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got ready=%b req=%b addr=%h wen=%b twen=%b done=%b err=%b expected all 0",
                     miss_ready, mem_req_valid, mem_req_addr, data_wen, tag_wen, done, err);
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        tick();
        checks++;
        if (miss_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_ready got=%b expected=1", miss_ready);
        end
    endtask

    task automatic test_nominal();
        int acc;
        logic [WORD_W-1:0] beats [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int i = 0; i < 4; i++) wr_q.push_back({6'h05, 2'(i), beats[i]});
        tag_q.push_back({6'h05, 21'h1ABCDE, 1'b0});
        mem_req_ready = 1'b1;
        issue_miss(6'h05, 20'hABCDE, acc);
        @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== {20'hABCDE, 6'h05}) begin
            errors++;
            $display("[TB] FAIL nominal_req got valid=%b addr=%h expected valid=1 addr=%h",
                     mem_req_valid, mem_req_addr, {20'hABCDE, 6'h05});
        end
        tick();
        for (int i = 0; i < 4; i++) drive_beat(1'b1, beats[i], i == 3);
        mem_rsp_valid = 1'b0;
        mem_rsp_last  = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || cyc - acc !== 6) begin
            errors++;
            $display("[TB] FAIL nominal_done got done=%b err=%b cycles=%0d expected done=1 err=0 cycles=6",
                     done, err, cyc - acc);
        end
        tick();
        checks++;
        if (done !== 1'b0 || miss_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL nominal_after got done=%b ready=%b expected done=0 ready=1", done, miss_ready);
        end
        check_drained("nominal");
    endtask

    task automatic test_stall();
        int acc;
        for (int i = 0; i < 4; i++) wr_q.push_back({6'h05, 2'(i), 32'hA0 + 32'(i)});
        tag_q.push_back({6'h05, 21'h1ABCDE, 1'b0});
        mem_req_ready = 1'b0;
        issue_miss(6'h05, 20'hABCDE, acc);
        // Stray beats while the request is stalled must not be written.
        for (int i = 0; i < 5; i++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'hBAD0 + 32'(i);
            @(negedge clk);
            checks++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== {20'hABCDE, 6'h05} || miss_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold cycle=%0d got valid=%b addr=%h ready=%b expected valid=1 addr=%h ready=0",
                         i, mem_req_valid, mem_req_addr, miss_ready, {20'hABCDE, 6'h05});
            end
            tick();
        end
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) drive_beat(1'b1, 32'hA0 + 32'(i), i == 3);
        mem_rsp_valid = 1'b0;
        mem_rsp_last  = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_done got=%b expected=1", done);
        end
        tick();
        check_drained("stall");
    endtask

    task automatic test_early_last();
        int acc;
        wr_q.push_back({6'h2A, 2'd0, 32'hCAFE_0000});
        wr_q.push_back({6'h2A, 2'd1, 32'hCAFE_0001});
        tag_q.push_back({6'h2A, 21'h012345, 1'b1});
        issue_miss(6'h2A, 20'h12345, acc);
        tick();
        drive_beat(1'b1, 32'hCAFE_0000, 1'b0);
        drive_beat(1'b1, 32'hCAFE_0001, 1'b1);
        mem_rsp_valid = 1'b0;
        mem_rsp_last  = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL early_last_pulse got done=%b err=%b expected done=1 err=1", done, err);
        end
        tick();
        check_drained("early_last");
    endtask

    task automatic test_missing_last();
        int acc;
        for (int i = 0; i < 4; i++) wr_q.push_back({6'h3F, 2'(i), 32'h5500 + 32'(i)});
        tag_q.push_back({6'h3F, 21'h0FFFFF, 1'b1});
        issue_miss(6'h3F, 20'hFFFFF, acc);
        tick();
        for (int i = 0; i < 4; i++) drive_beat(1'b1, 32'h5500 + 32'(i), 1'b0);
        mem_rsp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL missing_last_pulse got done=%b err=%b expected done=1 err=1", done, err);
        end
        tick();
        tick();
        mem_rsp_valid = 1'b0;
        checks++;
        if (miss_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL missing_last_idle got ready=%b expected=1", miss_ready);
        end
        check_drained("missing_last");
    endtask

    task automatic test_gapped();
        int acc;
        logic valid_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int n = 0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h5757_5757;
        mem_rsp_last  = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_last  = 1'b0;
        for (int i = 0; i < 4; i++) wr_q.push_back({6'h01, 2'(i), 32'h7000 + 32'(i)});
        tag_q.push_back({6'h01, 21'h100F0F, 1'b0});
        issue_miss(6'h01, 20'h00F0F, acc);
        @(negedge clk);
        checks++;
        if (miss_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL gapped_ready_busy got=%b expected=0", miss_ready);
        end
        tick();
        // A second miss during the fill must not disturb the captured index.
        miss_valid = 1'b1;
        miss_index = 6'h33;
        miss_tag   = 20'h33333;
        for (int i = 0; i < 7; i++) begin
            if (valid_pat[i]) begin
                drive_beat(1'b1, 32'h7000 + 32'(n), n == 3);
                n++;
            end else begin
                drive_beat(1'b0, 32'hFFFF_0000 + 32'(i), 1'b0);
            end
        end
        miss_valid    = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_last  = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL gapped_done got done=%b err=%b expected done=1 err=0", done, err);
        end
        tick();
        check_drained("gapped");
    endtask

    task automatic test_reset_mid_fill();
        int acc;
        wr_q.push_back({6'h10, 2'd0, 32'h0BAD_0000});
        wr_q.push_back({6'h10, 2'd1, 32'h0BAD_0001});
        issue_miss(6'h10, 20'hCAFE0, acc);
        tick();
        drive_beat(1'b1, 32'h0BAD_0000, 1'b0);
        drive_beat(1'b1, 32'h0BAD_0001, 1'b0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0BAD_0002;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({miss_ready, mem_req_valid, data_wen, data_waddr, data_wdata, tag_wen, done, err} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_fill_outputs got ready=%b req=%b wen=%b waddr=%h wdata=%h twen=%b done=%b err=%b expected all 0",
                     miss_ready, mem_req_valid, data_wen, data_waddr, data_wdata, tag_wen, done, err);
        end
        mem_rsp_valid = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        tick();
        checks++;
        if (miss_ready !== 1'b1 || tag_wen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_fill_release got ready=%b twen=%b expected ready=1 twen=0", miss_ready, tag_wen);
        end
        tick();
        tick();
        check_drained("reset_mid_fill");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stall();
        test_early_last();
        test_missing_last();
        test_gapped();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_refill_ctrl
